hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It shadows the rd/rs/control fields of the ID/EX, EX/MEM and MEM/WB stages. From these it drives the 2-bit select inputs of the two EX-stage operand forwarding multiplexers. It also raises the load-use stall and branch flush controls for IF/ID and ID/EX, and keeps saturating stall and flush event counters for debug.

Parameters:
REG_AW, 5, register-address width (x0..x31)
CNT_W, 32, width of stall/flush event counters

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous reset, active-high
id_valid  input  1  ID stage holds a valid instruction
id_rs1  input  REG_AW  rs1 of instruction in ID
id_rs2  input  REG_AW  rs2 of instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_rd  input  REG_AW  rd of instruction in ID
id_regwrite  input  1  ID instruction writes rd
id_memread  input  1  ID instruction is a load
branch_taken  input  1  EX resolved a taken branch/jump this cycle
forward_a  output  2  EX operand-A mux select: 00 regfile, 01 MEM/WB result, 10 EX/MEM ALU result, 11 never driven
forward_b  output  2  EX operand-B mux select, same encoding
stall  output  1  load-use hazard: hold PC and IF/ID, bubble ID/EX
pc_write  output  1  ~stall
ifid_write  output  1  ~stall
ifid_flush  output  1  kill IF/ID contents (= branch_taken)
idex_bubble  output  1  load zeros into ID/EX control (= stall | branch_taken)
stall_count  output  CNT_W  cycles with stall asserted, saturating
flush_count  output  CNT_W  cycles with branch_taken asserted, saturating

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset: all shadow registers clear to 0 (rd=0, regwrite=0, memread=0). Counters clear to 0. This gives forward_a/b=00, stall=0, pc_write=1, ifid_write=1. ifid_flush and idex_bubble follow branch_taken.
- Shadow pipeline, updated every cycle:
  - ex_* fields load from the id_* inputs, or load zeros when idex_bubble=1 or id_valid=0.
  - mem_rd/mem_regwrite load from ex_*.
  - wb_rd/wb_regwrite load from mem_*.
  - Stalls never freeze EX/MEM or MEM/WB.
- Forwarding is combinational from the registered shadow state, with zero added latency. For operand A:
  - 10 if mem_regwrite and mem_rd!=0 and mem_rd==ex_rs1;
  - else 01 if wb_regwrite and wb_rd!=0 and wb_rd==ex_rs1;
  - else 00.
  - The nearer stage (EX/MEM) wins when both match.
  - forward_b uses the same rule with ex_rs2.
  - A source register of x0 always yields 00.
- Load-use stall is combinational: stall=1 when all of the following hold:
  - id_valid and ex_memread and ex_rd!=0;
  - (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd);
  - branch_taken=0.
  - Exactly one stall cycle per load-use pair. The next cycle the load is in MEM and the bubble is in EX.
  - The consumer is re-presented to ID and gets forward 01 once it reaches EX.
- Flush priority: branch_taken overrides stall. The ID instruction is squashed anyway, so stall=0, ifid_flush=1 and idex_bubble=1.
- Counters increment by 1 per cycle on the rising edge while the respective condition holds. They hold at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush: the next edge clears all state regardless of inputs. Outputs return to reset values on the first cycle after rst.

Decomposition:
- Shared package pipe_pkg:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - REG_AW;
  - a stage-control struct {rd, regwrite, memread}.
- One natural sub-module: fwd_select. It is combinational and instanced twice (A and B), mapping {src, mem_rd, mem_regwrite, wb_rd, wb_regwrite} to a 2-bit select.

Test Plan:
- Back-to-back dependency: add x5 ← ..., then add x6 ← x5,x1 → on the consumer's EX cycle forward_a=10, forward_b=00, stall=0.
- One-instruction gap dependency: writer of x7, independent instruction, reader of x7 on rs2 → forward_b=01 in the reader's EX cycle.
- Double hit: writers of x9 in both MEM and WB, reader of x9 → forward_a=10, not 01. Writer to x0 followed by a reader of x0 → forward_a=00.
- Load-use: lw x3, then add x4 ← x3 → stall=1 for exactly one cycle; pc_write=0, idex_bubble=1; stall_count=1; next EX of the add shows forward_a=01.
- Load-use coinciding with branch_taken=1 → stall=0, ifid_flush=1, idex_bubble=1, flush_count increments, stall_count unchanged.
- Saturation and reset: preload counters near all-ones via a long stall run → counts hold at 2^CNT_W-1. Assert rst during a stall → next cycle stall=0, both counts=0, forward_a/b=00.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select encodings and the per-stage
// control fields shadowed by the hazard unit.
package pipe_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX-stage source register.
// EX/MEM takes priority over MEM/WB because it holds the younger result.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int unsigned AW = pipe_pkg::REG_AW
) (
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_regwrite,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_regwrite,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage core: operand forwarding selects,
// load-use stall, branch flush and saturating debug event counters.
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = pipe_pkg::REG_AW,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              branch_taken,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    stage_ctrl_t       ex_q, ex_d, mem_q, wb_q;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic              hit_rs1, hit_rs2;

    always_comb begin
        hit_rs1     = id_use_rs1 && (id_rs1 == ex_q.rd);
        hit_rs2     = id_use_rs2 && (id_rs2 == ex_q.rd);
        // A taken branch squashes the ID instruction, so it cannot stall.
        stall       = id_valid && ex_q.memread && (ex_q.rd != '0) &&
                      (hit_rs1 || hit_rs2) && !branch_taken;
        pc_write    = !stall;
        ifid_write  = !stall;
        ifid_flush  = branch_taken;
        idex_bubble = stall || branch_taken;
    end

    always_comb begin
        ex_d     = '0;
        ex_rs1_d = '0;
        ex_rs2_d = '0;
        if (id_valid && !idex_bubble) begin
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_rs1_d      = id_rs1;
            ex_rs2_d      = id_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            ex_q     <= ex_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            mem_q    <= ex_q;
            wb_q     <= mem_q;
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (branch_taken && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    fwd_select #(
        .AW (REG_AW)
    ) u_fwd_a (
        .src          (ex_rs1_q),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .wb_rd        (wb_q.rd),
        .wb_regwrite  (wb_q.regwrite),
        .sel          (forward_a)
    );

    fwd_select #(
        .AW (REG_AW)
    ) u_fwd_b (
        .src          (ex_rs2_q),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .wb_rd        (wb_q.rd),
        .wb_regwrite  (wb_q.regwrite),
        .sel          (forward_b)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: table of per-cycle ID inputs with expected
// outputs, pushed to a scoreboard on drive and popped at the falling edge.
module tb_hazard_forward_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 3;

    typedef struct packed {
        bit          rst;
        bit          valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          u1;
        bit          u2;
        logic [4:0]  rd;
        bit          rw;
        bit          mr;
        bit          br;
        bit          chk;
        logic [1:0]  fa;
        logic [1:0]  fb;
        bit          st;
        logic [2:0]  sc;
        logic [2:0]  fc;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          id_regwrite = 1'b0, id_memread = 1'b0, branch_taken = 1'b0;
    logic [1:0]    forward_a, forward_b;
    logic          stall, pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [CW-1:0] stall_count, flush_count;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    hazard_forward_unit #(
        .REG_AW (AW),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .branch_taken (branch_taken),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall        (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit v, int rs1, int rs2, bit u1, bit u2, int rd,
                                bit rw, bit mr, bit br, bit chk, int fa, int fb, bit st,
                                int sc, int fc);
        vec_t x;
        x.rst = r;   x.valid = v;  x.rs1 = 5'(rs1); x.rs2 = 5'(rs2);
        x.u1 = u1;   x.u2 = u2;    x.rd = 5'(rd);   x.rw = rw;  x.mr = mr;
        x.br = br;   x.chk = chk;  x.fa = 2'(fa);   x.fb = 2'(fb);
        x.st = st;   x.sc = 3'(sc); x.fc = 3'(fc);
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got %0h, required %0h", name, idx, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        rst = v.rst;  id_valid = v.valid;  id_rs1 = v.rs1;  id_rs2 = v.rs2;
        id_use_rs1 = v.u1;  id_use_rs2 = v.u2;  id_rd = v.rd;
        id_regwrite = v.rw;  id_memread = v.mr;  branch_taken = v.br;
        if (v.chk) exp_q.push_back(v);
        @(negedge clk);
        if (v.chk) begin
            e = exp_q.pop_front();
            check("forward_a",   idx, 32'(forward_a),   32'(e.fa));
            check("forward_b",   idx, 32'(forward_b),   32'(e.fb));
            check("stall",       idx, 32'(stall),       32'(e.st));
            check("pc_write",    idx, 32'(pc_write),    32'(!e.st));
            check("ifid_write",  idx, 32'(ifid_write),  32'(!e.st));
            check("ifid_flush",  idx, 32'(ifid_flush),  32'(e.br));
            check("idex_bubble", idx, 32'(idex_bubble), 32'(e.st | e.br));
            check("stall_count", idx, 32'(stall_count), 32'(e.sc));
            check("flush_count", idx, 32'(flush_count), 32'(e.fc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //               r v rs1 rs2 u1 u2 rd rw mr br chk fa fb st sc fc
        vecs.push_back(mk(1,0, 0, 0, 0,0, 0, 0,0,0, 0, 0,0,0, 0,0));
        vecs.push_back(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 0,0,0, 0,0)); // reset state
        vecs.push_back(mk(0,1, 1, 2, 1,1, 5, 1,0,0, 1, 0,0,0, 0,0)); // add x5
        vecs.push_back(mk(0,1, 5, 1, 1,1, 6, 1,0,0, 1, 0,0,0, 0,0)); // add x6<-x5,x1
        vecs.push_back(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 2,0,0, 0,0)); // consumer in EX
        vecs.push_back(mk(0,1, 0, 0, 0,0, 7, 1,0,0, 1, 0,0,0, 0,0)); // writer x7
        vecs.push_back(mk(0,1, 1, 2, 1,1, 8, 1,0,0, 1, 0,0,0, 0,0)); // independent
        vecs.push_back(mk(0,1, 1, 7, 1,1,10, 1,0,0, 1, 0,0,0, 0,0)); // reader x7 on rs2
        vecs.push_back(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 0,1,0, 0,0)); // forward_b=01
        vecs.push_back(mk(0,1, 0, 0, 0,0, 9, 1,0,0, 1, 0,0,0, 0,0)); // writer x9
        vecs.push_back(mk(0,1, 0, 0, 0,0, 9, 1,0,0, 1, 0,0,0, 0,0)); // writer x9
        vecs.push_back(mk(0,1, 9, 3, 1,1,11, 1,0,0, 1, 0,0,0, 0,0)); // reader x9
        vecs.push_back(mk(0,1, 0, 0, 0,0, 0, 1,0,0, 1, 2,0,0, 0,0)); // MEM wins; writer x0
        vecs.push_back(mk(0,1, 0, 0, 1,0,12, 1,0,0, 1, 0,0,0, 0,0)); // reader x0
        vecs.push_back(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 0,0,0, 0,0)); // x0 never forwarded
        vecs.push_back(mk(0,1, 1, 0, 1,0, 3, 1,1,0, 1, 0,0,0, 0,0)); // lw x3
        vecs.push_back(mk(0,1, 3, 2, 1,1, 4, 1,0,0, 1, 0,0,1, 0,0)); // add x4 stalls
        vecs.push_back(mk(0,1, 3, 2, 1,1, 4, 1,0,0, 1, 0,0,0, 1,0)); // re-presented
        vecs.push_back(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 1,0,0, 1,0)); // forward_a=01
        vecs.push_back(mk(0,1, 0, 0, 0,0,13, 1,1,0, 1, 0,0,0, 1,0)); // lw x13
        vecs.push_back(mk(0,1,13, 0, 1,0,14, 1,0,1, 1, 0,0,0, 1,0)); // load-use + branch
        vecs.push_back(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 0,0,0, 1,1));
        for (int k = 1; k <= 7; k++) begin                          // stall counter run
            vecs.push_back(mk(0,1, 0, 0, 0,0, 3, 1,1,0, 1, 0,0,0, k,1));
            vecs.push_back(mk(0,1, 3, 0, 1,0, 4, 1,0,0, 1, 0,0,1, k,1));
        end
        vecs.push_back(mk(0,1, 0, 0, 0,0, 3, 1,1,0, 1, 0,0,0, 7,1)); // saturated
        vecs.push_back(mk(1,1, 3, 0, 1,0, 4, 1,0,0, 0, 0,0,0, 0,0)); // rst during stall
        vecs.push_back(mk(0,1, 3, 0, 1,0, 4, 1,0,0, 1, 0,0,0, 0,0));
        vecs.push_back(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 0,0,0, 0,0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Long branch run saturates the flush counter.
        for (int k = 0; k < 9; k++) begin
            apply(mk(0,0, 0, 0, 0,0, 0, 0,0,1, 1, 0,0,0, 0, (k > 7) ? 7 : k), 100 + k);
        end
        apply(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 0,0,0, 0,7), 109);

        // Reset asserted while a branch is flushing clears the flush counter.
        apply(mk(1,0, 0, 0, 0,0, 0, 0,0,1, 0, 0,0,0, 0,0), 110);
        apply(mk(0,0, 0, 0, 0,0, 0, 0,0,0, 1, 0,0,0, 0,0), 111);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
